// File: rtl/hash_mem_pkg.sv
// Shared widths, defaults and types for the hash-core memory responder.
package hash_mem_pkg;

  localparam int NUM_PORTS = 16;
  localparam int ADDR_W    = 16;
  localparam int DATA_W    = 32;
  localparam int DEPTH     = 1024;
  localparam int PORT_W    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  typedef logic [PORT_W-1:0] port_idx_t;
  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] word_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr wins.
module rr_arbiter
  import hash_mem_pkg::*;
#(
  parameter int N  = 16,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] winner,
  output logic          any_gnt
);

  logic [2*N-1:0] req_dbl;
  logic [N-1:0]   req_rot;
  int             offset;
  int             win_sum;

  // Rotate so bit 0 is the port at ptr, then take the lowest set bit.
  always_comb begin
    req_dbl = {req, req};
    req_rot = N'(req_dbl >> ptr);
    any_gnt = 1'b0;
    offset  = 0;
    for (int j = 0; j < N; j++) begin
      if (!any_gnt && req_rot[j]) begin
        any_gnt = 1'b1;
        offset  = j;
      end
    end
    win_sum = int'(ptr) + offset;
    if (win_sum >= N) win_sum = win_sum - N;
    winner = win_sum[PW-1:0];
    gnt    = any_gnt ? (N'(1) << winner) : '0;
  end

endmodule

// File: rtl/hash_mem_responder.sv
// Serialises per-core read/write requests onto one word memory, returning
// read data one cycle after the grant, tagged to the granted core.
module hash_mem_responder #(
  parameter int NUM_PORTS = hash_mem_pkg::NUM_PORTS,
  parameter int ADDR_W    = hash_mem_pkg::ADDR_W,
  parameter int DATA_W    = hash_mem_pkg::DATA_W,
  parameter int DEPTH     = hash_mem_pkg::DEPTH
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_PORTS-1:0]        req,
  input  logic [NUM_PORTS-1:0]        we,
  input  logic [NUM_PORTS*ADDR_W-1:0] addr,
  input  logic [NUM_PORTS*DATA_W-1:0] wdata,
  output logic [NUM_PORTS-1:0]        gnt,
  output logic [NUM_PORTS-1:0]        rvalid,
  output logic [DATA_W-1:0]           rdata,
  output logic                        err
);
  import hash_mem_pkg::*;

  localparam int              PW        = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int              IW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W + 1)'(DEPTH);
  localparam logic [PW-1:0]   LAST_PORT = PW'(NUM_PORTS - 1);

  logic [PW-1:0]        rr_ptr_q, rr_ptr_d;
  logic [NUM_PORTS-1:0] rvalid_q, rvalid_d;
  logic [DATA_W-1:0]    rdata_q, rdata_d;
  logic                 err_q, err_d;

  logic [NUM_PORTS-1:0] arb_gnt;
  logic [PW-1:0]        winner;
  logic                 any_gnt;
  logic                 xfer;
  logic                 sel_we;
  logic [ADDR_W-1:0]    sel_addr;
  logic [DATA_W-1:0]    sel_wdata;
  logic                 in_range;
  logic [IW-1:0]        mem_idx;
  logic [DATA_W-1:0]    mem [DEPTH];

  rr_arbiter #(
    .N  (NUM_PORTS),
    .PW (PW)
  ) u_arb (
    .req     (req),
    .ptr     (rr_ptr_q),
    .gnt     (arb_gnt),
    .winner  (winner),
    .any_gnt (any_gnt)
  );

  assign gnt  = reset ? '0 : arb_gnt;
  assign xfer = any_gnt & ~reset;

  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (winner == PW'(i)) begin
        sel_we    = we[i];
        sel_addr  = addr[i*ADDR_W +: ADDR_W];
        sel_wdata = wdata[i*DATA_W +: DATA_W];
      end
    end
    in_range = {1'b0, sel_addr} < DEPTH_LIM;
    mem_idx  = sel_addr[IW-1:0];
  end

  // Out-of-range reads still answer (with zero) so the core is never left waiting.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    rvalid_d = '0;
    rdata_d  = rdata_q;
    err_d    = 1'b0;
    if (xfer) begin
      rr_ptr_d = (winner == LAST_PORT) ? '0 : winner + PW'(1);
      err_d    = ~in_range;
      if (!sel_we) begin
        rvalid_d = arb_gnt;
        rdata_d  = in_range ? mem[mem_idx] : '0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr_q <= '0;
      rvalid_q <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  // Memory is deliberately left out of reset so data survives a mid-run reset.
  always_ff @(posedge clk) begin
    if (xfer && sel_we && in_range) mem[mem_idx] <= sel_wdata;
  end

  assign rvalid = rvalid_q;
  assign rdata  = rdata_q;
  assign err    = err_q;

endmodule

// File: tb/tb_hash_mem_responder.sv
// Directed and randomized checks of hash_mem_responder against a behavioural
// model of arbitration order, memory contents and response timing.
module tb_hash_mem_responder;
  import hash_mem_pkg::*;

  localparam int N     = 16;
  localparam int AW    = 16;
  localparam int DW    = 32;
  localparam int DEPTH = 1024;

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  req, we;
  logic [N*AW-1:0] addr;
  logic [N*DW-1:0] wdata;
  logic [N-1:0]  gnt, rvalid;
  logic [DW-1:0] rdata;
  logic          err;

  hash_mem_responder #(
    .NUM_PORTS (N),
    .ADDR_W    (AW),
    .DATA_W    (DW),
    .DEPTH     (DEPTH)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .req    (req),
    .we     (we),
    .addr   (addr),
    .wdata  (wdata),
    .gnt    (gnt),
    .rvalid (rvalid),
    .rdata  (rdata),
    .err    (err)
  );

  always #5 clk = ~clk;

  int            checks = 0;
  int            errors = 0;
  bit            pend [N];
  bit            pwe [N];
  logic [AW-1:0] paddr [N];
  logic [DW-1:0] pwdata [N];
  int            wait_cnt [N];
  logic [DW-1:0] mem_model [int];
  int            ptr_model = 0;
  logic [DW-1:0] exp_rdata = '0;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus();
    for (int i = 0; i < N; i++) begin
      req[i]               = pend[i];
      we[i]                = pwe[i];
      addr[i*AW +: AW]     = paddr[i];
      wdata[i*DW +: DW]    = pwdata[i];
    end
  endtask

  function automatic int exp_winner();
    for (int k = 0; k < N; k++) begin
      int i;
      i = (ptr_model + k) % N;
      if (pend[i]) return i;
    end
    return -1;
  endfunction

  function automatic bit any_pend();
    for (int i = 0; i < N; i++) if (pend[i]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic post(input int port, input bit is_write, input int a, input logic [DW-1:0] d);
    pend[port]   = 1'b1;
    pwe[port]    = is_write;
    paddr[port]  = AW'(a);
    pwdata[port] = d;
  endtask

  // One clock: drive, check grant mid-cycle, then check registered responses.
  task automatic step_cycle(output int w);
    logic [N-1:0] exp_gnt, exp_rvalid;
    logic         exp_err;
    int           a;
    applyStimulus();
    @(negedge clk);
    w       = exp_winner();
    exp_gnt = (w < 0) ? '0 : (N'(1) << w);
    checkOutput("gnt", 64'(gnt), 64'(exp_gnt));
    for (int i = 0; i < N; i++) if (pend[i]) wait_cnt[i]++;
    @(posedge clk);
    #1;
    exp_rvalid = '0;
    exp_err    = 1'b0;
    if (w >= 0) begin
      checkOutput("wait_within_n", 64'(wait_cnt[w] <= N), 64'(1));
      a       = int'(paddr[w]);
      exp_err = (a >= DEPTH);
      if (pwe[w]) begin
        if (!exp_err) mem_model[a] = pwdata[w];
      end else begin
        exp_rvalid = N'(1) << w;
        exp_rdata  = exp_err ? '0 : mem_model[a];
      end
      ptr_model   = (w + 1) % N;
      pend[w]     = 1'b0;
      wait_cnt[w] = 0;
    end
    checkOutput("rvalid", 64'(rvalid), 64'(exp_rvalid));
    checkOutput("rdata", 64'(rdata), 64'(exp_rdata));
    checkOutput("err", 64'(err), 64'(exp_err));
  endtask

  task automatic drain();
    int w;
    int c;
    c = 0;
    while (any_pend() && c < 100) begin
      step_cycle(w);
      c++;
    end
    checkOutput("drain", 64'(any_pend()), 64'(0));
  endtask

  initial begin
    int w;
    for (int i = 0; i < N; i++) begin
      pend[i] = 1'b0; pwe[i] = 1'b0; paddr[i] = '0; pwdata[i] = '0; wait_cnt[i] = 0;
    end
    reset = 1'b1;
    applyStimulus();
    repeat (2) @(posedge clk);
    #1;
    pend[3] = 1'b1;
    applyStimulus();
    #1;
    checkOutput("reset_gnt", 64'(gnt), 64'(0));
    checkOutput("reset_rvalid", 64'(rvalid), 64'(0));
    checkOutput("reset_rdata", 64'(rdata), 64'(0));
    checkOutput("reset_err", 64'(err), 64'(0));
    pend[3] = 1'b0;
    applyStimulus();
    @(posedge clk);
    #1;
    reset = 1'b0;

    $display("[TB] preload mem[i]=i*4, then all ports read together");
    for (int i = 0; i < N; i++) post(i, 1'b1, i, DW'(i * 4));
    drain();
    for (int i = 0; i < N; i++) post(i, 1'b0, i, '0);
    for (int k = 0; k < N; k++) begin
      step_cycle(w);
      checkOutput("all_read_order", 64'(w), 64'(k));
      checkOutput("all_read_data", 64'(rdata), 64'(k * 4));
    end

    $display("[TB] single read of port 3");
    post(0, 1'b1, 5, 32'hDEADBEEF);
    step_cycle(w);
    post(3, 1'b0, 5, '0);
    step_cycle(w);
    checkOutput("single_rvalid", 64'(rvalid), 64'(16'h0008));
    checkOutput("single_rdata", 64'(rdata), 64'(32'hDEADBEEF));

    $display("[TB] write then read");
    post(0, 1'b1, 10, 32'h12345678);
    step_cycle(w);
    post(1, 1'b0, 10, '0);
    step_cycle(w);
    checkOutput("raw_rvalid", 64'(rvalid), 64'(16'h0002));
    checkOutput("raw_rdata", 64'(rdata), 64'(32'h12345678));

    $display("[TB] fairness between ports 2 and 14");
    post(15, 1'b0, 0, '0);
    step_cycle(w);
    checkOutput("fair_first", 64'(w), 64'(15));
    for (int k = 0; k < 8; k++) begin
      if (!pend[2]) post(2, 1'b0, 2, '0);
      if (!pend[14]) post(14, 1'b0, 14, '0);
      step_cycle(w);
      checkOutput("fair_seq", 64'(w), 64'((k % 2 == 0) ? 2 : 14));
    end
    drain();

    $display("[TB] out-of-range access on port 7");
    post(7, 1'b1, 16'h0400, 32'hCAFEF00D);
    step_cycle(w);
    checkOutput("oor_wr_err", 64'(err), 64'(1));
    checkOutput("oor_wr_rvalid", 64'(rvalid), 64'(0));
    post(7, 1'b0, 16'h0400, '0);
    step_cycle(w);
    checkOutput("oor_rd_rvalid", 64'(rvalid), 64'(16'h0080));
    checkOutput("oor_rd_rdata", 64'(rdata), 64'(0));
    checkOutput("oor_rd_err", 64'(err), 64'(1));
    post(0, 1'b0, 0, '0);
    step_cycle(w);
    checkOutput("oor_mem0", 64'(rdata), 64'(0));
    checkOutput("oor_err_clear", 64'(err), 64'(0));

    $display("[TB] reset during a read response");
    post(4, 1'b0, 10, '0);
    step_cycle(w);
    checkOutput("mid_rvalid_before", 64'(rvalid), 64'(16'h0010));
    reset = 1'b1;
    post(9, 1'b0, 10, '0);
    applyStimulus();
    #1;
    checkOutput("mid_rvalid", 64'(rvalid), 64'(0));
    checkOutput("mid_rdata", 64'(rdata), 64'(0));
    checkOutput("mid_gnt", 64'(gnt), 64'(0));
    ptr_model = 0;
    exp_rdata = '0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    post(2, 1'b0, 5, '0);
    step_cycle(w);
    checkOutput("post_reset_ptr", 64'(w), 64'(2));
    checkOutput("post_reset_rdata5", 64'(rdata), 64'(32'hDEADBEEF));
    step_cycle(w);
    checkOutput("post_reset_rdata10", 64'(rdata), 64'(32'h12345678));

    $display("[TB] randomized traffic");
    for (int c = 0; c < 300; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(0, 2) == 0) begin
          post(i, 1'($urandom_range(0, 1)), $urandom_range(0, 31), $urandom);
          if ($urandom_range(0, 7) == 0) paddr[i] = AW'($urandom_range(DEPTH, 16'hFFFF));
          if (!pwe[i] && paddr[i] < DEPTH && !mem_model.exists(int'(paddr[i]))) pwe[i] = 1'b1;
        end
      end
      step_cycle(w);
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
